// File: rtl/edg_pkg.sv
// Shared definitions for the edge-detection datapath: frame geometry,
// default alignment depths and the alignment-stage state encoding.
package edg_pkg;

    // Frame geometry of the edge-detection path
    localparam int PIX_W      = 18;
    localparam int H_ACTIVE   = 640;
    localparam int FILT_LINES = 3;

    // Default widths of the pixel word (two pixels) and the ZBT address
    localparam int DEF_DATA_W = 2 * PIX_W;
    localparam int DEF_ADDR_W = 19;

    // Data only has to cover the filter front-end registers; the address has
    // to cover the whole multi-line window plus the same front-end latency.
    localparam int DEF_DATA_DLY = 2;
    localparam int DEF_ADDR_DLY = 2 + FILT_LINES * H_ACTIVE;

    // Alignment-stage states
    typedef enum logic [1:0] {
        ALIGN_BYPASS = 2'd0,
        ALIGN_FILL   = 2'd1,
        ALIGN_RUN    = 2'd2
    } align_state_t;

endpackage : edg_pkg

// File: rtl/delay_ram.sv
// Circular address store: one write and one read port, asynchronous read so
// that a read and a write to the same entry in one cycle return the old value.
// Purely storage; pointer and enable come from the caller.
module delay_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_ptr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_ptr,
    output logic [WIDTH-1:0] rd_data
);

    // Storage is deliberately not reset: stale entries are never flagged
    // valid because the fill counter gates the output valid.
    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write the new entry on the clock edge; the read below still sees the
    // previous contents during that cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr];

endmodule : delay_ram

// File: rtl/pix_align_delay.sv
// Alignment delay for the edge-detection datapath. The pixel word goes
// through a short shift register, the matching write address through a long
// circular buffer, both advanced only on accepted beats so stalls do not
// disturb alignment. Adds frame resync, bypass and an output valid flag.
module pix_align_delay
    import edg_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_DLY = DEF_DATA_DLY,
    parameter int ADDR_DLY = DEF_ADDR_DLY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              frame_start,
    input  logic              bypass,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    // Reject depths that cannot be built
    if (DATA_DLY < 1) begin : g_bad_data_dly
        $error("pix_align_delay: DATA_DLY must be at least 1");
    end
    if (ADDR_DLY < 2) begin : g_bad_addr_dly
        $error("pix_align_delay: ADDR_DLY must be at least 2");
    end

    localparam int PTR_W  = $clog2(ADDR_DLY);
    localparam int FILL_W = $clog2(ADDR_DLY + 1);

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(ADDR_DLY - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(ADDR_DLY);

    localparam logic [1:0] ST_BYPASS = ALIGN_BYPASS;
    localparam logic [1:0] ST_FILL   = ALIGN_FILL;
    localparam logic [1:0] ST_RUN    = ALIGN_RUN;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  ptr_nxt_s;
    logic [PTR_W-1:0]  ptr_eff_s;
    logic [PTR_W-1:0]  ptr_inc_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_nxt_s;
    logic [FILL_W-1:0] fill_eff_s;
    logic [FILL_W-1:0] fill_inc_s;
    logic              fill_full_s;
    logic              beat_s;
    logic [ADDR_W-1:0] ram_rd_s;
    logic [DATA_W-1:0] sr_r [DATA_DLY];

    // A beat advances storage only outside bypass
    assign beat_s = in_valid & ~bypass;

    // frame_start restarts the frame on this very edge, so a beat that
    // coincides with it is handled as beat 0 (pointer 0, nothing filled).
    always_comb begin
        ptr_eff_s  = ptr_r;
        fill_eff_s = fill_r;
        if (frame_start) begin
            ptr_eff_s  = {PTR_W{1'b0}};
            fill_eff_s = {FILL_W{1'b0}};
        end else begin
            ptr_eff_s  = ptr_r;
            fill_eff_s = fill_r;
        end
    end

    assign fill_full_s = (fill_eff_s == FILL_FULL);

    // Pointer wrap and saturating fill count for the current beat
    always_comb begin
        ptr_inc_s  = ptr_eff_s;
        fill_inc_s = fill_eff_s;
        if (ptr_eff_s == PTR_LAST) begin
            ptr_inc_s = {PTR_W{1'b0}};
        end else begin
            ptr_inc_s = ptr_eff_s + PTR_W'(1);
        end
        if (fill_full_s) begin
            fill_inc_s = fill_eff_s;
        end else begin
            fill_inc_s = fill_eff_s + FILL_W'(1);
        end
    end

    // Next state, pointer and fill; bypass outranks frame_start outranks beat.
    // Pointer and fill are held at 0 in bypass, so the first edge after
    // bypass drops already behaves as the start of a fresh fill.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        fill_nxt_s  = fill_r;
        if (bypass) begin
            state_nxt_s = ST_BYPASS;
            ptr_nxt_s   = {PTR_W{1'b0}};
            fill_nxt_s  = {FILL_W{1'b0}};
        end else if (in_valid) begin
            ptr_nxt_s  = ptr_inc_s;
            fill_nxt_s = fill_inc_s;
            if (fill_inc_s == FILL_FULL) begin
                state_nxt_s = ST_RUN;
            end else begin
                state_nxt_s = ST_FILL;
            end
        end else begin
            ptr_nxt_s  = ptr_eff_s;
            fill_nxt_s = fill_eff_s;
            if (frame_start) begin
                state_nxt_s = ST_FILL;
            end else begin
                case (state_r)
                    ST_BYPASS: state_nxt_s = ST_FILL;
                    ST_FILL:   state_nxt_s = ST_FILL;
                    ST_RUN:    state_nxt_s = ST_RUN;
                    default:   state_nxt_s = ST_FILL;
                endcase
            end
        end
    end

    // Control registers: state, write pointer, fill counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_FILL;
            ptr_r   <= {PTR_W{1'b0}};
            fill_r  <= {FILL_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            fill_r  <= fill_nxt_s;
        end
    end

    // Data delay line, advanced once per accepted beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DATA_DLY; i++) begin
                sr_r[i] <= {DATA_W{1'b0}};
            end
        end else if (beat_s) begin
            sr_r[0] <= in_data;
            for (int i = 1; i < DATA_DLY; i++) begin
                sr_r[i] <= sr_r[i-1];
            end
        end
    end

    // Address delay: read the oldest entry and replace it with the new address
    delay_ram #(
        .DEPTH (ADDR_DLY),
        .WIDTH (ADDR_W),
        .AW    (PTR_W)
    ) u_delay_ram (
        .clk     (clk),
        .wr_en   (beat_s),
        .wr_ptr  (ptr_eff_s),
        .wr_data (in_addr),
        .rd_ptr  (ptr_eff_s),
        .rd_data (ram_rd_s)
    );

    // Output register: pass-through in bypass, aligned pair on a beat,
    // otherwise hold the pair and drop valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= {DATA_W{1'b0}};
            out_addr  <= {ADDR_W{1'b0}};
        end else if (bypass) begin
            out_valid <= in_valid;
            out_data  <= in_data;
            out_addr  <= in_addr;
        end else if (in_valid) begin
            out_valid <= fill_full_s;
            out_data  <= sr_r[DATA_DLY-1];
            out_addr  <= ram_rd_s;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule : pix_align_delay
